pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, is the PC value loaded on reset.
REQ-002 Parameter EXC_VEC, default 32'h0000_4180, is the exception entry address.
REQ-003 Parameter DELAY_SLOT, default 0; 0 means control transfers take effect next cycle, 1 means one delay-slot instruction executes first.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  freezes PC and internal state when high.
REQ-007 npc_sel  input  3  control class of instruction at pc: 0 sequential, 1 branch, 2 jump-to-index, 3 jump-to-register; values 4-7 are treated as 0.
REQ-008 zero  input  1  branch condition; a branch is taken only when zero=1.
REQ-009 imm32  input  32  sign-extended branch word offset.
REQ-010 instr_index  input  26  jump target index.
REQ-011 jump_reg  input  32  register jump target.
REQ-012 exc_req  input  1  exception entry request.
REQ-013 eret_req  input  1  exception return request.
REQ-014 epc  input  32  return address for eret_req.
REQ-015 pc  output  32  registered address of the instruction being fetched.
REQ-016 npc  output  32  combinational value pc takes at the next edge if nothing overrides it.
REQ-017 in_slot  output  1  registered; high while pc holds a delay-slot instruction.
REQ-018 target_misaligned  output  1  registered; one-cycle pulse when a taken transfer loads a target with bits [1:0] != 0.

Function
REQ-019 All arithmetic is modulo 2^32; carries out of bit 31 are discarded.
REQ-020 Branch target is pc + 4 + (imm32 << 2), computed from the branch's own pc.
REQ-021 Jump-to-index target is {P[31:28], instr_index, 2'b00}; P is pc when DELAY_SLOT=0 and pc+4 when DELAY_SLOT=1.
REQ-022 Jump-to-register target is jump_reg unmodified.
REQ-023 A transfer is taken when npc_sel is 2 or 3, or when npc_sel is 1 and zero=1.
REQ-024 The state machine has two states: SEQ (no pending target) and SLOT (target held in an internal 32-bit pending register).
REQ-025 In SEQ with DELAY_SLOT=0, a taken transfer loads pc with the target at the next edge; otherwise pc loads pc+4.
REQ-026 In SEQ with DELAY_SLOT=1, a taken transfer loads pc with pc+4, captures the target into the pending register, sets in_slot=1 and enters SLOT.
REQ-027 In SLOT, control inputs are ignored; the next edge loads pc with the pending target, clears in_slot and returns to SEQ.
REQ-028 While stall=1 and exc_req=eret_req=0, pc, state, pending register and in_slot hold; target_misaligned is 0; control inputs are not sampled.
REQ-029 Priority per edge: exc_req > eret_req > stall > normal sequencing.
REQ-030 exc_req=1 loads pc with EXC_VEC, discards any pending target, clears in_slot and enters SEQ, regardless of stall.
REQ-031 eret_req=1 with exc_req=0 loads pc with epc, discards any pending target, clears in_slot and enters SEQ, regardless of stall.
REQ-032 target_misaligned pulses high for the cycle after pc is loaded with a misaligned target; the target is still loaded unaltered (no internal trap).
REQ-033 npc reflects REQ-025..031 exactly, including the exc/eret/stall overrides.

Reset
REQ-034 While reset=1, pc=RESET_PC, in_slot=0, target_misaligned=0, state=SEQ and pending register=0, asserted asynchronously and independent of clk.
REQ-035 Reset asserted mid-SLOT discards the pending target; after release, the first edge loads RESET_PC+4 when inputs are sequential.

Verification
REQ-036 DELAY_SLOT=0, pc=32'h3000, npc_sel=1, zero=1, imm32=32'hFFFF_FFFF -> next pc=32'h3000; zero=0 -> 32'h3004.
REQ-037 DELAY_SLOT=1, pc=32'h3010, npc_sel=2, instr_index=26'h0000C40 -> pc=32'h3014 with in_slot=1, then pc=32'h3100 with in_slot=0.
REQ-038 DELAY_SLOT=1, jump taken then stall=1 for 3 cycles while in SLOT -> pc holds 32'h3014 and in_slot holds 1; after release, pc=target.
REQ-039 exc_req=1 and eret_req=1 with stall=1 in SLOT -> pc=32'h4180, in_slot=0; next cycle eret_req only, epc=32'h3020 -> pc=32'h3020.
REQ-040 npc_sel=3, jump_reg=32'h0000_3002 -> pc=32'h3002 and target_misaligned=1 for exactly one cycle.
REQ-041 pc=32'hFFFF_FFFC, sequential -> pc=32'h0000_0000; reset asserted between clock edges -> pc=32'h3000 immediately.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with optional single delay slot,
// exception entry / return overrides and a misaligned-target flag.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC    = 32'h0000_4180,
  parameter int          DELAY_SLOT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  npc_sel,
  input  logic        zero,
  input  logic [31:0] imm32,
  input  logic [25:0] instr_index,
  input  logic [31:0] jump_reg,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        in_slot,
  output logic        target_misaligned
);

  typedef enum logic {
    SEQ  = 1'b0,
    SLOT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        in_slot_q, in_slot_d;
  logic        mis_q, mis_d;

  logic [31:0] pc_plus4;
  logic [31:0] region_pc;
  logic [31:0] target;
  logic        taken;

  // Decode the control class of the instruction at pc into a target and a taken flag.
  always_comb begin
    pc_plus4  = pc_q + 32'd4;
    region_pc = (DELAY_SLOT != 0) ? pc_plus4 : pc_q;
    target    = pc_plus4;
    taken     = 1'b0;
    case (npc_sel)
      3'd1: begin
        target = pc_plus4 + (imm32 << 2);
        taken  = zero;
      end
      3'd2: begin
        target = {region_pc[31:28], instr_index, 2'b00};
        taken  = 1'b1;
      end
      3'd3: begin
        target = jump_reg;
        taken  = 1'b1;
      end
      default: begin
        target = pc_plus4;
        taken  = 1'b0;
      end
    endcase
  end

  // Next-state logic: exception > eret > stall > normal sequencing.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    in_slot_d = in_slot_q;
    mis_d     = 1'b0;
    if (exc_req) begin
      pc_d      = EXC_VEC;
      pend_d    = 32'h0;
      in_slot_d = 1'b0;
      state_d   = SEQ;
    end else if (eret_req) begin
      pc_d      = epc;
      pend_d    = 32'h0;
      in_slot_d = 1'b0;
      state_d   = SEQ;
    end else if (stall) begin
      // Everything holds; the misaligned flag drops to zero.
      mis_d = 1'b0;
    end else if (state_q == SLOT) begin
      // Delay slot done: control inputs are ignored, jump to the held target.
      pc_d      = pend_q;
      pend_d    = 32'h0;
      in_slot_d = 1'b0;
      state_d   = SEQ;
      mis_d     = |pend_q[1:0];
    end else if (taken && (DELAY_SLOT == 0)) begin
      pc_d  = target;
      mis_d = |target[1:0];
    end else if (taken) begin
      pc_d      = pc_plus4;
      pend_d    = target;
      in_slot_d = 1'b1;
      state_d   = SLOT;
    end else begin
      pc_d = pc_plus4;
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SEQ;
      pc_q      <= RESET_PC;
      pend_q    <= 32'h0;
      in_slot_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      in_slot_q <= in_slot_d;
      mis_q     <= mis_d;
    end
  end

  assign pc                = pc_q;
  assign npc               = pc_d;
  assign in_slot           = in_slot_q;
  assign target_misaligned = mis_q;

endmodule
